// File: rtl/dac_write_ctrl.sv
// Queued AD5300 write controller: buffers code/power-down requests and feeds them to the SPI master.
// Optional macro DAC_WRITE_CTRL_DEDUP_EN drops requests equal to the last accepted one.
module dac_write_ctrl #(
   parameter int DEPTH   = 4,
   parameter int CODE_W  = 8,
   parameter int FRAME_W = 16,
   parameter int TIMEOUT = 4
) (
   input  logic                     clk_i,
   input  logic                     arst_i,
   input  logic                     req_i,
   input  logic [CODE_W-1:0]        code_i,
   input  logic [1:0]               pd_i,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     ovf_o,
   output logic                     err_o,
   input  logic                     clr_i,
   output logic [FRAME_W-1:0]       spi_data_o,
   output logic                     spi_wre_o,
   input  logic                     spi_rdy_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = CODE_W + 2;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t               state_q, state_d;
   logic [EW-1:0]        mem_q [DEPTH];
   logic [EW-1:0]        mem_d [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        count_q, count_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [FRAME_W-1:0]   data_q, data_d;
   logic                 wre_q, wre_d, done_q, done_d;
   logic                 ovf_q, ovf_d, err_q, err_d;
   logic [EW-1:0]        entry;
   logic [FRAME_W-1:0]   head_frame;
   logic                 full, dup, push, reject, pop, set_err;

   assign entry      = {pd_i, code_i};
   assign head_frame = FRAME_W'({2'b00, mem_q[rd_ptr_q], 4'b0000});
   assign full       = (count_q == LW'(DEPTH));

`ifdef DAC_WRITE_CTRL_DEDUP_EN
   logic [EW-1:0] last_q, last_d;
   logic          last_vld_q, last_vld_d;

   assign dup = last_vld_q && (entry == last_q);

   // An accepted push re-arms the filter even if clr_i arrives in the same cycle.
   always_comb begin
      last_d     = last_q;
      last_vld_d = last_vld_q;
      if (push) begin
         last_d     = entry;
         last_vld_d = 1'b1;
      end else if (clr_i) begin
         last_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign push   = req_i && !full && !dup;
   assign reject = req_i && full && !dup;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      data_d  = data_q;
      wre_d   = 1'b0;
      done_d  = 1'b0;
      pop     = 1'b0;
      set_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0 && spi_rdy_i) begin
               data_d  = head_frame;
               wre_d   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            tmr_d   = TW'(TIMEOUT - 1);
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!spi_rdy_i) begin
               state_d = WAIT_DONE;
            end else if (tmr_q == '0) begin
               // SPI master never acknowledged: drop the entry rather than stall the queue.
               set_err = 1'b1;
               pop     = 1'b1;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         WAIT_DONE: begin
            if (spi_rdy_i) begin
               pop     = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = entry;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + LW'(push) - LW'(pop);
      ovf_d   = reject  ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
      err_d   = set_err ? 1'b1 : (clr_i ? 1'b0 : err_q);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tmr_q    <= '0;
         data_q   <= '0;
         wre_q    <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tmr_q    <= tmr_d;
         data_q   <= data_d;
         wre_q    <= wre_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign full_o     = full;
   assign level_o    = count_q;
   assign busy_o     = (state_q != IDLE) || (count_q != '0);
   assign done_o     = done_q;
   assign ovf_o      = ovf_q;
   assign err_o      = err_q;
   assign spi_data_o = data_q;
   assign spi_wre_o  = wre_q;

endmodule
